// File: rtl/aes_inv_cipher.sv
// AES inverse cipher, one round per clock. Round keys come from an external
// combinational key store addressed by rk_idx. A tag rides along with each block.
module aes_inv_cipher #(
  parameter int ID_W   = 4,
  parameter int MAX_NR = 14
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_word,
  input  logic [1:0]      in_key_len,
  input  logic [ID_W-1:0] in_id,
  output logic [3:0]      rk_idx,
  input  logic [127:0]    rk,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_word,
  output logic [ID_W-1:0] out_id,
  output logic            out_err
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

  localparam logic [3:0] MAX_NR_L = 4'(MAX_NR);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] isbox(input logic [7:0] b);
    return INV_SBOX[8*(255-int'(b)) +: 8];
  endfunction

  // GF(2^8) multiply by a 4-bit constant (0e/0b/0d/09 are all that is needed)
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = {b[6:0], 1'b0}  ^ (b[7]  ? 8'h1b : 8'h00);
    x4 = {x2[6:0], 1'b0} ^ (x2[7] ? 8'h1b : 8'h00);
    x8 = {x4[6:0], 1'b0} ^ (x4[7] ? 8'h1b : 8'h00);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  // byte n of the state sits at [127-8n -: 8]; row r, column c is byte 4c+r
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = isbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  state_t            r_state;
  logic [127:0]      r_data;
  logic [3:0]        r_cnt;
  logic [ID_W-1:0]   r_id;

  logic [3:0]        w_nr;
  logic              w_legal;
  logic              w_accept;
  logic [127:0]      w_sr;
  logic [127:0]      w_round;
  logic [127:0]      w_final;

  assign in_ready = (r_state == IDLE) | ((r_state == OUT) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_sr     = inv_shift_sub(r_data);
  assign w_final  = w_sr ^ rk;
  assign w_round  = inv_mix(w_final);

  // round count for the offered block and whether this instance can run it
  always_comb begin
    w_nr = 4'd10;
    case (in_key_len)
      2'b01:   w_nr = 4'd12;
      2'b10:   w_nr = 4'd14;
      default: w_nr = 4'd10;
    endcase
    w_legal = (in_key_len != 2'b11) && (w_nr <= MAX_NR_L);
  end

  // round key address: last key on accept, counter during rounds, 0 otherwise
  always_comb begin
    rk_idx = 4'd0;
    if (w_accept)
      rk_idx = w_legal ? w_nr : 4'd0;
    else if (r_state == ROUND)
      rk_idx = r_cnt;
  end

  // control FSM, datapath and registered result
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_cnt     <= '0;
      r_id      <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_id    <= '0;
      out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, OUT: begin
          if (r_state == OUT && out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
          // an accept in OUT overrides the return to IDLE above
          if (w_accept) begin
            r_id <= in_id;
            if (w_legal) begin
              r_data  <= in_word ^ rk;
              r_cnt   <= w_nr - 4'd1;
              r_state <= ROUND;
            end else begin
              out_valid <= 1'b1;
              out_word  <= '0;
              out_id    <= in_id;
              out_err   <= 1'b1;
              r_state   <= OUT;
            end
          end
        end
        ROUND: begin
          if (abort) begin
            r_state <= IDLE;
          end else begin
            r_data <= w_round;
            r_cnt  <= r_cnt - 4'd1;
            if (r_cnt == 4'd1)
              r_state <= FINAL;
          end
        end
        FINAL: begin
          if (abort) begin
            r_state <= IDLE;
          end else begin
            out_valid <= 1'b1;
            out_word  <= w_final;
            out_id    <= r_id;
            out_err   <= 1'b0;
            r_state   <= OUT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors, stall/back-to-back, abort,
// reset during FINAL, and an unsupported-key-length instance.
module tb_aes_inv_cipher;

  logic         clk;
  logic         srst;
  logic         in_valid, b_in_valid;
  logic         in_ready, b_in_ready;
  logic [127:0] in_word;
  logic [1:0]   in_key_len;
  logic [3:0]   in_id;
  logic [3:0]   rk_idx, b_rk_idx;
  logic [127:0] rk, b_rk;
  logic         abort;
  logic         out_valid, b_out_valid;
  logic         out_ready;
  logic [127:0] out_word, b_out_word;
  logic [3:0]   out_id, b_out_id;
  logic         out_err, b_out_err;

  logic [127:0] ktab [0:15];
  logic [7:0]   sbox [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] w;
    logic [3:0]   id;
    logic         err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]   kl;
    logic [127:0] ct;
    logic [3:0]   id;
    logic [127:0] pt;
    logic         err;
    int           lat;
  } vec_t;

  assign rk   = ktab[rk_idx];
  assign b_rk = ktab[b_rk_idx];

  aes_inv_cipher #(.ID_W(4), .MAX_NR(14)) dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_key_len(in_key_len), .in_id(in_id),
    .rk_idx(rk_idx), .rk(rk), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_id(out_id), .out_err(out_err)
  );

  aes_inv_cipher #(.ID_W(4), .MAX_NR(10)) dut10 (
    .clk(clk), .srst(srst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_word(in_word), .in_key_len(in_key_len), .in_id(in_id),
    .rk_idx(b_rk_idx), .rk(b_rk), .abort(abort), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_word(b_out_word), .out_id(b_out_id), .out_err(b_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // forward S-box from its definition: multiplicative inverse + affine map
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // key bytes are 00,01,02,...; nk = 4/6/8 words
  task automatic load_key(input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++)
      w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      ktab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // from just after the accept edge, count cycles until out_valid and audit rk_idx
  task automatic wait_out(input int nr, output int cyc, output int bad);
    bit done;
    int exp_idx;
    cyc = 1;
    bad = 0;
    done = 0;
    while (!done && cyc <= 40) begin
      @(negedge clk);
      exp_idx = (cyc <= nr) ? nr - cyc : 0;
      if (rk_idx !== 4'(exp_idx)) bad++;
      if (out_valid) done = 1;
      else begin
        tick();
        cyc++;
      end
    end
    if (!done) begin
      $display("FAIL wait_out: timeout, out_valid not seen within 40 cycles");
      cyc = 99;
    end
  endtask

  function automatic int nr_of(input logic [1:0] kl);
    return (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 0;
  endfunction

  // scoreboard consumer: compare every handshaked result against the queue
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!srst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got id %h word %h, expected no output", out_id, out_word);
      end else begin
        e = sb.pop_front();
        check("out_word", out_word, e.w);
        check("out_id", 128'(out_id), 128'(e.id));
        check("out_err", 128'(out_err), 128'(e.err));
      end
    end
  end

  initial begin : main
    vec_t vt [4];
    int   cyc, bad, nr, cnt;

    build_sbox();
    vt[0] = '{kl: 2'd0, ct: CT128, id: 4'd3, pt: PT,     err: 1'b0, lat: 11};
    vt[1] = '{kl: 2'd1, ct: CT192, id: 4'd5, pt: PT,     err: 1'b0, lat: 13};
    vt[2] = '{kl: 2'd2, ct: CT256, id: 4'd9, pt: PT,     err: 1'b0, lat: 15};
    vt[3] = '{kl: 2'd3, ct: CT128, id: 4'ha, pt: 128'h0, err: 1'b1, lat: 1};

    srst = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0; in_word = '0;
    in_key_len = '0; in_id = '0; abort = 1'b0; out_ready = 1'b1;
    for (int r = 0; r < 16; r++) ktab[r] = '0;

    tick();
    tick();
    @(negedge clk);
    check("rst out_valid", 128'(out_valid), 128'd0);
    check("rst out_word", out_word, 128'd0);
    check("rst out_id", 128'(out_id), 128'd0);
    check("rst out_err", 128'(out_err), 128'd0);
    check("rst in_ready", 128'(in_ready & b_in_ready), 128'd1);
    check("rst rk_idx", 128'(rk_idx), 128'd0);
    tick();
    srst = 1'b0;

    // table-driven vectors, out_ready held high
    foreach (vt[i]) begin
      nr = nr_of(vt[i].kl);
      if (nr != 0) load_key(nr - 6);
      tick();
      in_valid = 1'b1; in_word = vt[i].ct; in_key_len = vt[i].kl; in_id = vt[i].id;
      sb.push_back('{w: vt[i].pt, id: vt[i].id, err: vt[i].err});
      @(negedge clk);
      check("accept in_ready", 128'(in_ready), 128'd1);
      check("accept rk_idx", 128'(rk_idx), 128'(nr));
      tick();
      in_valid = 1'b0;
      wait_out(nr, cyc, bad);
      check("latency", 128'(cyc), 128'(vt[i].lat));
      check("rk_idx sequence errors", 128'(bad), 128'd0);
      tick();
      @(negedge clk);
      check("back to idle", 128'({out_valid, in_ready}), 128'b01);
    end

    // stall in OUT for 5 cycles, then accept + abort together with the drain
    load_key(4);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1; in_word = CT128; in_key_len = 2'd0; in_id = 4'd1;
    sb.push_back('{w: PT, id: 4'd1, err: 1'b0});
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    wait_out(10, cyc, bad);
    check("stall first latency", 128'(cyc), 128'd11);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      if (out_word !== PT || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("stall hold errors", 128'(bad), 128'd0);
    tick();
    in_valid = 1'b1; in_id = 4'd2; out_ready = 1'b1; abort = 1'b1;
    sb.push_back('{w: PT, id: 4'd2, err: 1'b0});
    @(negedge clk);
    check("b2b in_ready", 128'(in_ready), 128'd1);
    check("b2b rk_idx", 128'(rk_idx), 128'd10);
    tick();
    in_valid = 1'b0; abort = 1'b0;
    wait_out(10, cyc, bad);
    check("b2b latency", 128'(cyc), 128'd11);
    check("b2b rk_idx sequence errors", 128'(bad), 128'd0);
    tick();

    // abort in the 4th ROUND cycle
    tick();
    in_valid = 1'b1; in_word = CT128; in_key_len = 2'd0; in_id = 4'd4;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort cycle rk_idx", 128'(rk_idx), 128'd6);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("after abort idle", 128'({out_valid, in_ready}), 128'b01);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("aborted block outputs", 128'(cnt), 128'd0);
    load_key(6);
    tick();
    in_valid = 1'b1; in_word = CT192; in_key_len = 2'd1; in_id = 4'd5;
    sb.push_back('{w: PT, id: 4'd5, err: 1'b0});
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    wait_out(12, cyc, bad);
    check("post-abort latency", 128'(cyc), 128'd13);
    tick();

    // reset asserted during FINAL
    load_key(4);
    tick();
    in_valid = 1'b1; in_word = CT128; in_key_len = 2'd0; in_id = 4'd6;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    srst = 1'b1;
    @(negedge clk);
    check("final rk_idx", 128'(rk_idx), 128'd0);
    tick();
    srst = 1'b0;
    @(negedge clk);
    check("srst out_valid", 128'(out_valid), 128'd0);
    check("srst out_word", out_word, 128'd0);
    check("srst out_id/err", 128'({out_id, out_err}), 128'd0);
    check("srst in_ready", 128'(in_ready), 128'd1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("reset block outputs", 128'(cnt), 128'd0);

    // AES-256 on an instance limited to 10 rounds
    tick();
    b_in_valid = 1'b1; in_word = CT256; in_key_len = 2'd2; in_id = 4'd7;
    @(negedge clk);
    check("nr10 in_ready", 128'(b_in_ready), 128'd1);
    check("nr10 rk_idx", 128'(b_rk_idx), 128'd0);
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    check("nr10 out_valid", 128'(b_out_valid), 128'd1);
    check("nr10 out_word", b_out_word, 128'd0);
    check("nr10 out_err", 128'(b_out_err), 128'd1);
    check("nr10 out_id", 128'(b_out_id), 128'd7);
    tick();

    check("scoreboard drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
